// File: rtl/multicycle_mips.sv
// multicycle_mips: five-state multicycle MIPS subset core with handshaked instruction and data memories
module multicycle_mips #(
    parameter int          DADDR_W  = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        IR_addr,
    output logic               IR_req,
    input  logic [31:0]        IR,
    input  logic               IR_valid,
    output logic               CEN,
    output logic               WEN,
    output logic               OEN,
    output logic [DADDR_W-1:0] A,
    output logic [31:0]        ReadData2,
    input  logic [31:0]        ReadDataMem,
    input  logic               mem_ready,
    output logic               RF_we,
    output logic [31:0]        RF_writedata,
    output logic               retire
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, pc4, jtarget, btarget, rs_val, rt_val, alu_y, alu_res;
    logic        is_r, is_alu_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, is_jal, valid;

    logic        ret, rf_we_i, pc_ld, ir_ld, ab_ld, alu_ld, mdr_ld;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd, pc_nx;

    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign simm     = {{16{ir[15]}}, ir[15:0]};
    assign pc4      = pc + 32'd4;
    assign jtarget  = {pc4[31:28], ir[25:0], 2'b00};
    assign btarget  = pc4 + {simm[29:0], 2'b00};
    assign rs_val   = rf[rs];
    assign rt_val   = rf[rt];

    assign is_r     = op == 6'h00;
    assign is_alu_r = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                               funct == 6'h25 || funct == 6'h2A);
    assign is_jr    = is_r && funct == 6'h08;
    assign is_lw    = op == 6'h23;
    assign is_sw    = op == 6'h2B;
    assign is_beq   = op == 6'h04;
    assign is_bne   = op == 6'h05;
    assign is_addi  = op == 6'h08;
    assign is_j     = op == 6'h02;
    assign is_jal   = op == 6'h03;
    assign valid    = is_alu_r | is_jr | is_lw | is_sw | is_beq | is_bne | is_addi | is_j | is_jal;

    assign alu_y    = is_r ? b_reg : simm;
    assign alu_res  = !is_r           ? a_reg + alu_y :
                      funct == 6'h22  ? a_reg - b_reg :
                      funct == 6'h24  ? a_reg & b_reg :
                      funct == 6'h25  ? a_reg | b_reg :
                      funct == 6'h2A  ? {31'b0, $signed(a_reg) < $signed(b_reg)} :
                                        a_reg + b_reg;

    assign IR_addr      = pc;
    assign IR_req       = state == FETCH && !rst;
    assign CEN          = !(state == MEM && !rst);
    assign WEN          = !(state == MEM && is_sw && !rst);
    assign OEN          = 1'b0;
    assign A            = alu_out[DADDR_W+1:2];
    assign ReadData2    = b_reg;
    assign RF_we        = rf_we_i && !rst;
    assign RF_writedata = RF_we ? rf_wd : 32'h0;
    assign retire       = ret && !rst;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    // next state and per-state control strobes
    always_comb begin
        state_nx = state;
        ret      = 1'b0;
        rf_we_i  = 1'b0;
        rf_wa    = 5'd0;
        rf_wd    = 32'h0;
        pc_ld    = 1'b0;
        pc_nx    = pc4;
        ir_ld    = 1'b0;
        ab_ld    = 1'b0;
        alu_ld   = 1'b0;
        mdr_ld   = 1'b0;
        case (state)
            FETCH: begin
                ir_ld    = IR_valid;
                state_nx = IR_valid ? DECODE : FETCH;
            end
            DECODE: begin
                ab_ld = 1'b1;
                if (is_j || is_jal || is_jr || !valid) begin
                    pc_ld    = 1'b1;
                    pc_nx    = is_jr ? rs_val : (is_j || is_jal) ? jtarget : pc4;
                    rf_we_i  = is_jal;
                    rf_wa    = 5'd31;
                    rf_wd    = pc4;
                    ret      = 1'b1;
                    state_nx = FETCH;
                end else begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (is_beq || is_bne) begin
                    pc_ld    = 1'b1;
                    pc_nx    = ((a_reg == b_reg) == is_beq) ? btarget : pc4;
                    ret      = 1'b1;
                    state_nx = FETCH;
                end else begin
                    alu_ld   = 1'b1;
                    state_nx = (is_lw || is_sw) ? MEM : WB;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    mdr_ld   = is_lw;
                    pc_ld    = is_sw;
                    ret      = is_sw;
                    state_nx = is_sw ? FETCH : WB;
                end
            end
            WB: begin
                rf_we_i  = 1'b1;
                rf_wa    = is_r ? rd : rt;
                rf_wd    = is_lw ? mdr : alu_out;
                pc_ld    = 1'b1;
                ret      = 1'b1;
                state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    // datapath latches: PC, instruction, operands, ALU result, memory data
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= 32'h0;
            a_reg   <= 32'h0;
            b_reg   <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
        end else begin
            if (ir_ld)  ir      <= IR;
            if (ab_ld)  a_reg   <= rs_val;
            if (ab_ld)  b_reg   <= rt_val;
            if (alu_ld) alu_out <= alu_res;
            if (mdr_ld) mdr     <= ReadDataMem;
            if (pc_ld)  pc      <= pc_nx;
        end
    end

    // register file; $0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (rf_we_i && rf_wa != 5'd0) begin
            rf[rf_wa] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_multicycle_mips.sv
// tb_multicycle_mips: directed program run against multicycle_mips with hand-computed expectations
module tb_multicycle_mips;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR_addr, IR, ReadData2, ReadDataMem, RF_writedata;
    logic        IR_req, IR_valid, CEN, WEN, OEN, mem_ready, RF_we, retire;
    logic [6:0]  A;
    logic [31:0] imem [0:127];
    int          total = 0, bad = 0, writes = 0, n;

    multicycle_mips dut (
        .clk(clk), .rst(rst), .IR_addr(IR_addr), .IR_req(IR_req), .IR(IR), .IR_valid(IR_valid),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .ReadData2(ReadData2), .ReadDataMem(ReadDataMem),
        .mem_ready(mem_ready), .RF_we(RF_we), .RF_writedata(RF_writedata), .retire(retire)
    );

    always #5 clk = ~clk;

    assign IR          = imem[IR_addr[8:2]];
    assign ReadDataMem = 32'hDEADBEEF;

    // count committed data-memory writes
    always @(posedge clk) if (!CEN && !WEN && mem_ready) writes++;

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input int lat);
        n = 1;
        while (!retire && n < 50) begin
            tick;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
        imem[0]  = i_ins(6'h08, 0, 1, 16'd5);
        imem[1]  = i_ins(6'h08, 0, 2, 16'hFFFD);
        imem[2]  = r_ins(2, 1, 3, 6'h2A);
        imem[3]  = r_ins(1, 2, 4, 6'h22);
        imem[4]  = j_ins(6'h03, 26'h40);
        imem[5]  = i_ins(6'h08, 0, 0, 16'd7);
        imem[6]  = i_ins(6'h2B, 0, 0, 16'd4);
        imem[7]  = j_ins(6'h02, 26'd8);
        imem[8]  = i_ins(6'h05, 1, 2, 16'hFFFE);
        imem[9]  = j_ins(6'h3F, 26'h0);
        imem[10] = i_ins(6'h2B, 0, 1, 16'd12);
        imem[64] = i_ins(6'h2B, 0, 1, 16'd8);
        imem[65] = i_ins(6'h23, 0, 5, 16'd8);
        imem[66] = r_ins(31, 0, 0, 6'h08);

        rst = 1'b1; IR_valid = 1'b1; mem_ready = 1'b1;
        tick; tick; tick;
        chk("rst_ir_req", IR_req, 0);
        chk("rst_cen", CEN, 1);
        chk("rst_wen", WEN, 1);
        chk("rst_rf_we", RF_we, 0);
        chk("rst_wdata", RF_writedata, 0);
        chk("rst_retire", retire, 0);
        chk("rst_a", A, 0);
        chk("rst_rd2", ReadData2, 0);
        chk("rst_pc", IR_addr, 0);
        chk("oen", OEN, 0);
        rst = 1'b0;
        #1;
        chk("ir_req_rise", IR_req, 1);

        run("addi1", 4); chk("addi1_we", RF_we, 1); chk("addi1_wd", RF_writedata, 32'd5);
        tick; chk("pc_4", IR_addr, 32'h4);
        run("addi2", 4); chk("addi2_wd", RF_writedata, 32'hFFFFFFFD);
        tick; chk("pc_8", IR_addr, 32'h8);
        run("slt", 4); chk("slt_wd", RF_writedata, 32'd1);
        tick;
        run("sub", 4); chk("sub_wd", RF_writedata, 32'd8);
        tick; chk("pc_10", IR_addr, 32'h10);
        run("jal", 2); chk("jal_we", RF_we, 1); chk("jal_wd", RF_writedata, 32'h14);
        tick; chk("pc_100", IR_addr, 32'h100);

        mem_ready = 1'b0;
        chk("fetch_cen", CEN, 1);
        repeat (3) tick;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                mem_ready = 1'b1;
                #1;
            end
            chk("sw_cen", CEN, 0);
            chk("sw_wen", WEN, 0);
            chk("sw_a", A, 2);
            chk("sw_rd2", ReadData2, 5);
            chk("sw_retire", retire, k == 3);
            if (k < 3) tick;
        end
        tick; chk("pc_104", IR_addr, 32'h104); chk("sw_writes", writes, 1);

        run("lw", 5); chk("lw_we", RF_we, 1); chk("lw_wd", RF_writedata, 32'hDEADBEEF);
        tick;
        run("jr", 2);
        tick; chk("pc_14", IR_addr, 32'h14);
        run("addi0", 4); chk("addi0_we", RF_we, 1);
        tick;
        run("sw0", 4); chk("sw0_rd2", ReadData2, 0); chk("sw0_a", A, 1);
        tick; chk("pc_1c", IR_addr, 32'h1C);
        run("j", 2);
        tick; chk("pc_20", IR_addr, 32'h20);
        run("bne", 3);
        tick; chk("bne_pc", IR_addr, 32'h1C);
        imem[8] = i_ins(6'h04, 1, 2, 16'hFFFE);
        run("j2", 2);
        tick;
        run("beq", 3);
        tick; chk("beq_pc", IR_addr, 32'h24);
        run("bad_op", 2); chk("bad_op_we", RF_we, 0);
        tick; chk("pc_28", IR_addr, 32'h28);

        mem_ready = 1'b0;
        repeat (3) tick;
        chk("stall_cen", CEN, 0);
        chk("stall_a", A, 3);
        imem[0] = i_ins(6'h08, 1, 7, 16'd0);
        rst = 1'b1;
        tick;
        mem_ready = 1'b1;
        #1;
        chk("abort_cen", CEN, 1);
        chk("abort_ir_req", IR_req, 0);
        chk("abort_pc", IR_addr, 0);
        chk("abort_we", RF_we, 0);
        rst = 1'b0; IR_valid = 1'b0;
        tick; tick;
        chk("fwait_req", IR_req, 1);
        chk("fwait_pc", IR_addr, 0);
        chk("fwait_retire", retire, 0);
        IR_valid = 1'b1;
        run("after_rst", 4); chk("rf_cleared", RF_writedata, 0); chk("abort_writes", writes, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_mips.md
MULTICYCLE_MIPS -- requirements
Module: multicycle_mips

Interface
REQ-001 Parameter DADDR_W, default 7: data-memory word-address width.
REQ-002 Parameter RESET_PC, default 32'h0: PC value loaded at reset.
REQ-003 clk  input  1  single clock, all state on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 IR_addr  output  32  instruction fetch address, equals PC.
REQ-006 IR_req  output  1  fetch request, high only in FETCH.
REQ-007 IR  input  32  instruction word, sampled when IR_req and IR_valid are both high.
REQ-008 IR_valid  input  1  instruction memory ready/valid.
REQ-009 CEN  output  1  data-memory chip enable, active low.
REQ-010 WEN  output  1  data-memory write enable: 0 = write, 1 = read.
REQ-011 OEN  output  1  data-memory output enable, constant 0.
REQ-012 A  output  DADDR_W  data word address, equal to ALU result [DADDR_W+1:2].
REQ-013 ReadData2  output  32  store data (rt value).
REQ-014 ReadDataMem  input  32  load data, sampled when mem_ready is high in MEM.
REQ-015 mem_ready  input  1  data-memory access complete.
REQ-016 RF_we  output  1  register-file write strobe; high only in the cycle a write commits.
REQ-017 RF_writedata  output  32  value being written; 0 when RF_we is low.
REQ-018 retire  output  1  one-cycle pulse in the final cycle of each instruction.

Function
REQ-019 ISA: add, sub, and, or, slt, jr (R-type, funct 20/22/24/25/2A/08); lw 23, sw 2B, beq 04, bne 05, addi 08, j 02, jal 03 (opcodes hex).
REQ-020 Unsupported opcode or funct: no register or memory side effect; PC advances by 4; retire in DECODE.
REQ-021 FSM states: FETCH, DECODE, EXEC, MEM, WB.
REQ-022 FETCH: hold IR_req=1 and IR_addr=PC until IR_valid; then latch IR into the instruction register and go to DECODE.
REQ-023 DECODE: read rs/rt into the A/B latches. j and jr load their target into PC and retire. jal writes PC+4 to $31, loads its target, and retires. All other instructions go to EXEC.
REQ-024 EXEC, beq/bne: compare A with B, set PC = taken ? PC+4+(sext(imm)<<2) : PC+4, and retire. lw/sw compute A+sext(imm) and go to MEM. R-type and addi latch the ALU result and go to WB.
REQ-025 MEM: CEN=0; WEN=1 for lw, 0 for sw. A and ReadData2 stay stable until the cycle mem_ready is sampled high. On that cycle, sw retires with PC+=4; lw latches ReadDataMem and goes to WB.
REQ-026 WB: write the destination register (rd for R-type, rt for addi/lw), PC+=4, retire, go to FETCH.
REQ-027 Minimum latency with zero-wait memories: j/jr/jal 2, beq/bne 3, R-type/addi/sw 4, lw 5 cycles; each wait cycle adds exactly 1.
REQ-028 Outside MEM: CEN=1 and WEN=1.
REQ-029 Writes to $0 are discarded, but RF_we still pulses; $0 always reads 0.
REQ-030 slt is signed. add/sub/addi wrap modulo 2^32 and raise no exception.
REQ-031 Jump target = {PC+4[31:28], imm26, 2'b00}.
REQ-032 Register file has 32x32 entries with asynchronous read and a write that commits on the clock edge.

Reset
REQ-033 While rst is high at a posedge: PC=RESET_PC, state=FETCH, all 32 registers=0, instruction/A/B latches=0.
REQ-034 Outputs during and right after reset: IR_req=0 while rst is high, CEN=1, WEN=1, RF_we=0, RF_writedata=0, retire=0, A=0, ReadData2=0.
REQ-035 Reset asserted mid-FETCH or mid-MEM aborts the instruction without any register or memory side effect; CEN returns to 1 in the cycle after the reset edge.
REQ-036 IR_req rises in the first cycle after rst deasserts.

Verification
REQ-037 Reset, then addi $1,$0,5 and addi $2,$0,-3 with IR_valid always high: retire at cycles 4 and 8, RF_writedata 5 then 32'hFFFFFFFD, IR_addr 0, 4, 8.
REQ-038 slt $3,$2,$1 after REQ-037 -> $3=1; sub $4,$1,$2 -> 8.
REQ-039 sw $1,8($0) with mem_ready delayed 3 cycles: CEN=0, WEN=0, A=2, ReadData2=5 held stable for 4 cycles; retire in the 7th cycle.
REQ-040 lw $5,8($0) with ReadDataMem=32'hDEADBEEF and zero wait: RF_we in cycle 5, $5=32'hDEADBEEF.
REQ-041 bne $1,$2,-2 at PC=0x20 -> next IR_addr 0x1C. beq on the same operands -> 0x24.
REQ-042 jal 0x40 at PC=0x10 -> $31=0x14, IR_addr=0x100 after 2 cycles; then jr $31 -> IR_addr=0x14; addi $0,$0,7 leaves $0=0.
